// File: rtl/clk_time_set_ctrl.sv
// rtl/clk_time_set_ctrl.sv - time-set controller: pause, edit HH:MM:SS in BCD, load back
module clk_time_set_ctrl #(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [3:0] cur_hr_l_i,
  input  logic [3:0] cur_hr_r_i,
  input  logic [3:0] cur_min_l_i,
  input  logic [3:0] cur_min_r_i,
  input  logic [3:0] cur_sec_l_i,
  input  logic [3:0] cur_sec_r_i,
  output logic       run_en_o,
  output logic       load_o,
  output logic [3:0] set_hr_l_o,
  output logic [3:0] set_hr_r_o,
  output logic [3:0] set_min_l_o,
  output logic [3:0] set_min_r_o,
  output logic [3:0] set_sec_l_o,
  output logic [3:0] set_sec_r_o,
  output logic [1:0] edit_field_o,
  output logic       blink_on_o
);

  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HR     = 3'd1;
  localparam logic [2:0] ST_MIN    = 3'd2;
  localparam logic [2:0] ST_SEC    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);

  logic [2:0]    state_q, state_d;
  logic          mode_q, inc_q;
  logic [3:0]    hr_l_q, hr_l_d, hr_r_q, hr_r_d;
  logic [3:0]    min_l_q, min_l_d, min_r_q, min_r_d;
  logic [3:0]    sec_l_q, sec_l_d, sec_r_q, sec_r_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] div_q, div_d;
  logic          blink_q, blink_d;

  logic mode_e, inc_e, in_set, timed_out;

  // Any illegal value (bad digit or out-of-range pair) wraps straight to 00.
  function automatic logic [7:0] inc_hr(input logic [3:0] l, input logic [3:0] r);
    if (l > 4'd2 || r > 4'd9 || (l == 4'd2 && r >= 4'd3)) return 8'h00;
    else if (r == 4'd9) return {l + 4'd1, 4'd0};
    else return {l, r + 4'd1};
  endfunction

  function automatic logic [7:0] inc_ms(input logic [3:0] l, input logic [3:0] r);
    if (l > 4'd5 || r > 4'd9 || (l == 4'd5 && r == 4'd9)) return 8'h00;
    else if (r == 4'd9) return {l + 4'd1, 4'd0};
    else return {l, r + 4'd1};
  endfunction

  assign mode_e    = btn_mode_i & ~mode_q;
  assign inc_e     = btn_inc_i & ~inc_q;
  assign in_set    = (state_q == ST_HR) || (state_q == ST_MIN) || (state_q == ST_SEC);
  assign timed_out = in_set && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    hr_l_d  = hr_l_q;
    hr_r_d  = hr_r_q;
    min_l_d = min_l_q;
    min_r_d = min_r_q;
    sec_l_d = sec_l_q;
    sec_r_d = sec_r_q;
    case (state_q)
      ST_RUN: begin
        if (mode_e) begin
          {hr_l_d, hr_r_d}   = {cur_hr_l_i, cur_hr_r_i};
          {min_l_d, min_r_d} = {cur_min_l_i, cur_min_r_i};
          {sec_l_d, sec_r_d} = {cur_sec_l_i, cur_sec_r_i};
          state_d = ST_HR;
        end
      end
      ST_HR: begin
        if (mode_e)         state_d = ST_MIN;
        else if (inc_e)     {hr_l_d, hr_r_d} = inc_hr(hr_l_q, hr_r_q);
        else if (timed_out) state_d = ST_RUN;
      end
      ST_MIN: begin
        if (mode_e)         state_d = ST_SEC;
        else if (inc_e)     {min_l_d, min_r_d} = inc_ms(min_l_q, min_r_q);
        else if (timed_out) state_d = ST_RUN;
      end
      ST_SEC: begin
        if (mode_e)         state_d = ST_COMMIT;
        else if (inc_e)     {sec_l_d, sec_r_d} = inc_ms(sec_l_q, sec_r_q);
        else if (timed_out) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Timeout and blink restart whenever the field changes, so a new field starts visible.
  always_comb begin
    to_cnt_d = '0;
    div_d    = '0;
    blink_d  = 1'b0;
    if (in_set && state_d == state_q) begin
      if (!(mode_e || inc_e)) to_cnt_d = to_cnt_q + TW'(1);
      if (div_q == BL_LAST) begin
        blink_d = ~blink_q;
      end else begin
        div_d   = div_q + BW'(1);
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_RUN;
      mode_q   <= 1'b0;
      inc_q    <= 1'b0;
      hr_l_q   <= '0;
      hr_r_q   <= '0;
      min_l_q  <= '0;
      min_r_q  <= '0;
      sec_l_q  <= '0;
      sec_r_q  <= '0;
      to_cnt_q <= '0;
      div_q    <= '0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= btn_mode_i;
      inc_q    <= btn_inc_i;
      hr_l_q   <= hr_l_d;
      hr_r_q   <= hr_r_d;
      min_l_q  <= min_l_d;
      min_r_q  <= min_r_d;
      sec_l_q  <= sec_l_d;
      sec_r_q  <= sec_r_d;
      to_cnt_q <= to_cnt_d;
      div_q    <= div_d;
      blink_q  <= blink_d;
    end
  end

  assign run_en_o    = (state_q == ST_RUN);
  assign load_o      = (state_q == ST_COMMIT);
  assign set_hr_l_o  = hr_l_q;
  assign set_hr_r_o  = hr_r_q;
  assign set_min_l_o = min_l_q;
  assign set_min_r_o = min_r_q;
  assign set_sec_l_o = sec_l_q;
  assign set_sec_r_o = sec_r_q;
  assign blink_on_o  = blink_q;

  always_comb begin
    edit_field_o = 2'b00;
    case (state_q)
      ST_HR:   edit_field_o = 2'b01;
      ST_MIN:  edit_field_o = 2'b10;
      ST_SEC:  edit_field_o = 2'b11;
      default: edit_field_o = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// tb/tb_clk_time_set_ctrl.sv - directed bench for clk_time_set_ctrl with a load scoreboard
module tb_clk_time_set_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, btn_mode, btn_inc;
  logic [3:0] cur_hr_l, cur_hr_r, cur_min_l, cur_min_r, cur_sec_l, cur_sec_r;
  logic       run_en, load, blink_on;
  logic [3:0] set_hr_l, set_hr_r, set_min_l, set_min_r, set_sec_l, set_sec_r;
  logic [1:0] edit_field;

  int n_cmp = 0;
  int n_bad = 0;
  int load_cnt = 0;
  int base;
  logic [23:0] exp_q[$];

  clk_time_set_ctrl #(.BLINK_DIV(4), .TIMEOUT_CYC(20)) dut (
    .clk_i(clk), .reset_i(reset), .btn_mode_i(btn_mode), .btn_inc_i(btn_inc),
    .cur_hr_l_i(cur_hr_l), .cur_hr_r_i(cur_hr_r),
    .cur_min_l_i(cur_min_l), .cur_min_r_i(cur_min_r),
    .cur_sec_l_i(cur_sec_l), .cur_sec_r_i(cur_sec_r),
    .run_en_o(run_en), .load_o(load),
    .set_hr_l_o(set_hr_l), .set_hr_r_o(set_hr_r),
    .set_min_l_o(set_min_l), .set_min_r_o(set_min_r),
    .set_sec_l_o(set_sec_l), .set_sec_r_o(set_sec_r),
    .edit_field_o(edit_field), .blink_on_o(blink_on)
  );

  function automatic logic [23:0] obs_set();
    return {set_hr_l, set_hr_r, set_min_l, set_min_r, set_sec_l, set_sec_r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; any load pulse is scored against the oldest expected commit.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (load === 1'b1) begin
      load_cnt++;
      chk("load_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("load_set", 32'(obs_set()), 32'(exp_q.pop_front()));
      chk("run_en_during_load", 32'(run_en), 0);
    end
  endtask

  task automatic set_cur(input logic [23:0] v);
    {cur_hr_l, cur_hr_r, cur_min_l, cur_min_r, cur_sec_l, cur_sec_r} = v;
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b0;
    cyc();
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    cyc();
    btn_inc = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    set_cur(24'h000000);

    // 1. reset state
    repeat (10) cyc();
    chk("rst_run_en", 32'(run_en), 1);
    chk("rst_load", 32'(load), 0);
    reset = 1'b0;
    cyc();
    chk("rst_edit_field", 32'(edit_field), 0);
    chk("rst_set", 32'(obs_set()), 0);
    chk("rst_blink", 32'(blink_on), 0);
    chk("rst_run_en_after", 32'(run_en), 1);

    // 2. hours 22->23->00, minutes 58->59, commit
    set_cur(24'h225859);
    press_mode();
    chk("t2_edit_hr", 32'(edit_field), 1);
    chk("t2_run_en_off", 32'(run_en), 0);
    chk("t2_capture", 32'(obs_set()), 32'h225859);
    press_inc();
    chk("t2_hr_23", 32'(obs_set()), 32'h235859);
    press_inc();
    chk("t2_hr_wrap", 32'(obs_set()), 32'h005859);
    press_mode();
    chk("t2_edit_min", 32'(edit_field), 2);
    press_inc();
    chk("t2_min_59", 32'(obs_set()), 32'h005959);
    press_mode();
    chk("t2_edit_sec", 32'(edit_field), 3);
    exp_q.push_back(24'h005959);
    btn_mode = 1'b1;
    cyc();
    chk("t2_load_high", 32'(load), 1);
    chk("t2_edit_commit", 32'(edit_field), 0);
    btn_mode = 1'b0;
    cyc();
    chk("t2_load_low", 32'(load), 0);
    chk("t2_run_en_back", 32'(run_en), 1);
    chk("t2_load_count", 32'(load_cnt), 1);
    chk("t2_set_stable", 32'(obs_set()), 32'h005959);

    // 3. hours 09->10; minutes 59->00 without carry into hours
    set_cur(24'h090909);
    press_mode();
    press_inc();
    chk("t3_hr_09_10", 32'(obs_set()), 32'h100909);
    press_mode();
    press_mode();
    exp_q.push_back(24'h100909);
    press_mode();
    chk("t3_load_count", 32'(load_cnt), 2);
    set_cur(24'h125930);
    press_mode();
    press_mode();
    press_inc();
    chk("t3_min_wrap", 32'(obs_set()), 32'h120030);
    press_mode();
    press_inc();
    chk("t3_sec_inc", 32'(obs_set()), 32'h120031);
    exp_q.push_back(24'h120031);
    press_mode();
    chk("t3_load_count2", 32'(load_cnt), 3);
    chk("t3_run_en", 32'(run_en), 1);

    // 4. idle timeout in SET_HR, with blink cadence
    set_cur(24'h010203);
    base = load_cnt;
    btn_mode = 1'b1;
    cyc();
    chk("t4_edit_hr", 32'(edit_field), 1);
    chk("t4_blink_entry", 32'(blink_on), 0);
    btn_mode = 1'b0;
    cyc();
    for (int k = 2; k <= 19; k++) begin
      cyc();
      chk($sformatf("t4_blink_k%0d", k), 32'(blink_on), 32'((k / 4) % 2));
    end
    chk("t4_still_editing", 32'(run_en), 0);
    chk("t4_still_hr", 32'(edit_field), 1);
    cyc();
    chk("t4_timeout_run_en", 32'(run_en), 1);
    chk("t4_timeout_edit", 32'(edit_field), 0);
    chk("t4_blink_run", 32'(blink_on), 0);
    chk("t4_no_load", 32'(load_cnt), 32'(base));
    chk("t4_set_kept", 32'(obs_set()), 32'h010203);

    // 5. simultaneous edges: mode wins; held inc gives one increment
    set_cur(24'h051020);
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    cyc();
    chk("t5_mode_wins", 32'(edit_field), 2);
    chk("t5_hr_unchanged", 32'(obs_set()), 32'h051020);
    chk("t5_blink_new_field", 32'(blink_on), 0);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    cyc();
    btn_inc = 1'b1;
    cyc();
    chk("t5_one_inc", 32'(obs_set()), 32'h051120);
    repeat (49) cyc();
    chk("t5_held_inc", 32'(obs_set()), 32'h051120);
    chk("t5_timeout_run_en", 32'(run_en), 1);
    btn_inc = 1'b0;
    cyc();

    // 6. reset mid-edit, then illegal capture wraps to 00
    set_cur(24'h070809);
    base = load_cnt;
    press_mode();
    press_mode();
    chk("t6_edit_min", 32'(edit_field), 2);
    press_inc();
    chk("t6_min_inc", 32'(obs_set()), 32'h070909);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_rst_run_en", 32'(run_en), 1);
    chk("t6_rst_edit", 32'(edit_field), 0);
    chk("t6_rst_set", 32'(obs_set()), 0);
    cyc();
    chk("t6_rst_no_load", 32'(load_cnt), 32'(base));
    set_cur(24'hF36012);
    press_mode();
    chk("t6_illegal_capture", 32'(obs_set()), 32'hF36012);
    press_inc();
    chk("t6_illegal_hr", 32'(obs_set()), 32'h006012);
    press_mode();
    press_inc();
    chk("t6_illegal_min", 32'(obs_set()), 32'h000012);
    press_mode();
    press_inc();
    exp_q.push_back(24'h000013);
    press_mode();
    chk("t6_load_count", 32'(load_cnt), 32'(base + 1));
    chk("pending_loads", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
